// File: rtl/saradc_dig_chseq_pkg.sv
// Shared types and width helpers for the SAR ADC channel sequencer.
package saradc_dig_chseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_CONV = 3'd2,
    ST_WAIT = 3'd3,
    ST_PUSH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    AVG_1 = 2'd0,
    AVG_2 = 2'd1,
    AVG_4 = 2'd2,
    AVG_8 = 2'd3
  } avg_e;

  // Headroom so that up to eight full-scale samples sum without wrapping.
  localparam int ACC_GUARD_W = 3;
  localparam int SAMP_CNT_W  = 4;

  function automatic int acc_width(input int result_msb);
    return result_msb + 1 + ACC_GUARD_W;
  endfunction

  function automatic int data_width(input int chnr_msb, input int result_msb);
    return chnr_msb + result_msb + 2;
  endfunction

endpackage

// File: rtl/saradc_dig_chseq_fifo.sv
// Small synchronous result FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. Read data reads as zero when empty.
module saradc_dig_chseq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? '0 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (rd_en) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/saradc_dig_chseq.sv
// Multi-channel SAR ADC conversion sequencer with per-channel averaging and a
// result FIFO. Define SARADC_DIG_CHSEQ_WDOG_EN to enable the eoc watchdog.
module saradc_dig_chseq
  import saradc_dig_chseq_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int CHNR_MSB   = 4,
  parameter int RESULT_MSB = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int WDOG_CYC   = 255
) (
  input  logic                           clk_i,
  input  logic                           res_i,
  input  logic                           trig_i,
  input  logic                           cont_i,
  input  logic [NCH-1:0]                 ch_mask_i,
  input  logic [1:0]                     avg_cfg_i,
  output logic                           start_adc_o,
  output logic [CHNR_MSB:0]              chnr_o,
  input  logic                           busy_i,
  input  logic                           eoc_i,
  input  logic [RESULT_MSB:0]            result_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [CHNR_MSB+RESULT_MSB+1:0] res_data_o,
  output logic                           scan_busy_o,
  output logic                           scan_done_o,
  output logic                           ovr_o,
  output logic                           wdog_err_o
);
  localparam int CHW   = CHNR_MSB + 1;
  localparam int RW    = RESULT_MSB + 1;
  localparam int ACC_W = acc_width(RESULT_MSB);
  localparam int DW    = data_width(CHNR_MSB, RESULT_MSB);
  localparam int IDXW  = CHW + 1;

  if (NCH < 2 || NCH > 32 || (1 << CHW) < NCH) begin : g_bad_nch
    $error("saradc_dig_chseq: NCH out of range for CHNR_MSB");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("saradc_dig_chseq: FIFO_DEPTH must be a power of two >= 2");
  end
  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("saradc_dig_chseq: WDOG_CYC must be >= 1");
  end

  state_e                state_q, state_d;
  avg_e                  avg_q;
  logic [NCH-1:0]        mask_q;
  logic [IDXW-1:0]       idx_q;
  logic [SAMP_CNT_W-1:0] cnt_q;
  logic [SAMP_CNT_W-1:0] n_samp;
  logic [ACC_W-1:0]      acc_q;
  logic [CHW-1:0]        sel_ch;
  logic                  more_ch;
  logic                  last_samp;
  logic                  accept;
  logic                  wdog_hit;
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DW-1:0]         fifo_wdata;

  assign accept    = (state_q == ST_IDLE) && trig_i && (|ch_mask_i);
  assign n_samp    = SAMP_CNT_W'(1) << avg_q;
  assign last_samp = (cnt_q + SAMP_CNT_W'(1)) == n_samp;

  // Lowest enabled channel at or above the scan index.
  always_comb begin
    sel_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) sel_ch = CHW'(i);
    end
  end

  always_comb begin
    more_ch = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i] && (i > int'(chnr_o))) more_ch = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEL;
      ST_SEL:  state_d = ST_CONV;
      ST_CONV: if (!busy_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (eoc_i)         state_d = last_samp ? ST_PUSH : ST_CONV;
        else if (wdog_hit) state_d = ST_IDLE;
      end
      ST_PUSH: state_d = (more_ch || cont_i) ? ST_SEL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_adc_o = 1'b0;
    fifo_push   = 1'b0;
    scan_done_o = 1'b0;
    case (state_q)
      ST_CONV: start_adc_o = !busy_i;
      ST_PUSH: begin
        fifo_push   = 1'b1;
        scan_done_o = !more_ch && !cont_i;
      end
      default: ;
    endcase
  end

  assign scan_busy_o = (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      mask_q <= '0;
      avg_q  <= AVG_1;
      idx_q  <= '0;
      chnr_o <= '0;
      cnt_q  <= '0;
      ovr_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          mask_q <= ch_mask_i;
          avg_q  <= avg_e'(avg_cfg_i);
          idx_q  <= '0;
          ovr_o  <= 1'b0;
        end
        ST_SEL: begin
          chnr_o <= sel_ch;
          cnt_q  <= '0;
        end
        ST_WAIT: if (eoc_i) cnt_q <= cnt_q + SAMP_CNT_W'(1);
        ST_PUSH: begin
          if (fifo_full && !fifo_pop) ovr_o <= 1'b1;
          idx_q <= more_ch ? (IDXW'(chnr_o) + IDXW'(1)) : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == ST_SEL)                acc_q <= '0;
    else if (state_q == ST_WAIT && eoc_i) acc_q <= acc_q + ACC_W'(result_i);
  end

`ifdef SARADC_DIG_CHSEQ_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_cnt_q;
  logic           wdog_err_q;

  // Counts consecutive WAIT cycles; restarts each time WAIT is re-entered.
  assign wdog_hit = (state_q == ST_WAIT) && !eoc_i && (wdog_cnt_q == WDW'(WDOG_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT) wdog_cnt_q <= wdog_cnt_q + WDW'(1);
      else                    wdog_cnt_q <= '0;
      if (wdog_hit)    wdog_err_q <= 1'b1;
      else if (accept) wdog_err_q <= 1'b0;
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  assign wdog_hit   = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  assign fifo_pop    = res_ready_i && !fifo_empty;
  assign fifo_wdata  = {chnr_o, RW'(acc_q >> avg_q)};
  assign res_valid_o = !fifo_empty;

  saradc_dig_chseq_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (res_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (res_ready_i),
    .rdata (res_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_saradc_dig_chseq.sv
// Directed bench for saradc_dig_chseq with a queue-based scan model and an
// ADC responder that answers each start_adc_o with the next planned result.
module tb_saradc_dig_chseq;
  localparam int NCH = 8;
  localparam int CHW = 5;
  localparam int RW  = 11;
  localparam int DW  = 16;

  logic           clk_i = 1'b0;
  logic           res_i = 1'b1;
  logic           trig_i = 1'b0;
  logic           cont_i = 1'b0;
  logic [NCH-1:0] ch_mask_i = '0;
  logic [1:0]     avg_cfg_i = '0;
  logic           start_adc_o;
  logic [CHW-1:0] chnr_o;
  logic           busy_i;
  logic           eoc_i;
  logic [RW-1:0]  result_i;
  logic           res_valid_o;
  logic           res_ready_i = 1'b0;
  logic [DW-1:0]  res_data_o;
  logic           scan_busy_o;
  logic           scan_done_o;
  logic           ovr_o;
  logic           wdog_err_o;

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int done_cnt = 0;
  bit started = 0;

  int            plan_res[$];
  int            res_q[$];
  int            exp_ch[$];
  logic [DW-1:0] exp_q[$];

  saradc_dig_chseq dut (
    .clk_i       (clk_i),
    .res_i       (res_i),
    .trig_i      (trig_i),
    .cont_i      (cont_i),
    .ch_mask_i   (ch_mask_i),
    .avg_cfg_i   (avg_cfg_i),
    .start_adc_o (start_adc_o),
    .chnr_o      (chnr_o),
    .busy_i      (busy_i),
    .eoc_i       (eoc_i),
    .result_i    (result_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .scan_busy_o (scan_busy_o),
    .scan_done_o (scan_done_o),
    .ovr_o       (ovr_o),
    .wdog_err_o  (wdog_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scan model: enabled channels ascending, 2^avg samples each, truncated mean.
  task automatic plan(input logic [NCH-1:0] mask, input int avg, input int npass);
    int k = 0;
    for (int p = 0; p < npass; p++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (mask[ch]) begin
          int sum = 0;
          logic [DW-1:0] w;
          for (int s = 0; s < (1 << avg); s++) begin
            sum += plan_res[k];
            res_q.push_back(plan_res[k]);
            exp_ch.push_back(ch);
            k++;
          end
          w = {CHW'(ch), RW'(sum / (1 << avg))};
          exp_q.push_back(w);
        end
      end
    end
    plan_res.delete();
  endtask

  // ADC responder: eoc three cycles after start, busy held one cycle past eoc.
  initial begin
    int cd = 0;
    int tail = 0;
    logic st;
    eoc_i = 1'b0; result_i = '0; busy_i = 1'b0;
    forever begin
      @(negedge clk_i);
      st = started && (start_adc_o === 1'b1);
      if (st) begin
        n_start++;
        chk("start_while_busy", busy_i, 0);
        if (exp_ch.size() == 0) chk("chnr_unexpected_start", 1, 0);
        else chk("chnr_seq", chnr_o, exp_ch.pop_front());
      end
      @(posedge clk_i); #1;
      eoc_i = 1'b0;
      if (st) cd = 2;
      else if (cd > 0) begin
        cd--;
        if (cd == 0 && res_q.size() > 0) begin
          eoc_i = 1'b1;
          result_i = RW'(res_q.pop_front());
          tail = 2;
        end
      end else if (tail > 0) tail--;
      busy_i = (cd > 0) || (tail > 0);
    end
  end

  // Output compare: every FIFO pop against the model, zero data when empty.
  always @(negedge clk_i) begin
    if (started) begin
      if (scan_done_o) done_cnt++;
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) chk("pop_unexpected", res_data_o, 0);
        else chk("fifo_word", res_data_o, exp_q.pop_front());
      end
      if (!res_valid_o) chk("data_when_empty", res_data_o, 0);
    end
  end

  task automatic trig(input logic [NCH-1:0] m, input logic [1:0] a);
    @(posedge clk_i); #1;
    ch_mask_i = m; avg_cfg_i = a; trig_i = 1'b1;
    @(posedge clk_i); #1;
    trig_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (scan_busy_o && n < maxc);
    chk(name, scan_busy_o, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(posedge clk_i); #1;
    res_ready_i = 1'b1;
    do begin
      @(negedge clk_i);
      n++;
    end while ((exp_q.size() != 0 || res_valid_o) && n < 100);
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, start_adc_o, 0);
    chk({tag, "_chnr"}, chnr_o, 0);
    chk({tag, "_valid"}, res_valid_o, 0);
    chk({tag, "_data"}, res_data_o, 0);
    chk({tag, "_busy"}, scan_busy_o, 0);
    chk({tag, "_done"}, scan_done_o, 0);
    chk({tag, "_ovr"}, ovr_o, 0);
    chk({tag, "_wdog"}, wdog_err_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0;
    int n0;
    int n;
    repeat (2) @(posedge clk_i);
    #1 res_i = 1'b0;
    started = 1;
    @(negedge clk_i);
    check_all_zero("reset");

    // Zero mask: trigger ignored.
    trig('0, 2'd0);
    @(negedge clk_i); chk("mask0_busy_a", scan_busy_o, 0);
    @(negedge clk_i); chk("mask0_busy_b", scan_busy_o, 0);

    // Single scan, avg 1, FIFO held then drained.
    plan_res = '{100, 200, 300};
    plan(8'hA1, 0, 1);
    chk("model_w0", exp_q[0], {5'd0, 11'd100});
    chk("model_w1", exp_q[1], {5'd5, 11'd200});
    chk("model_w2", exp_q[2], {5'd7, 11'd300});
    d0 = done_cnt;
    @(posedge clk_i); #1;
    ch_mask_i = 8'hA1; avg_cfg_i = 2'd0; trig_i = 1'b1;
    @(negedge clk_i); chk("busy_cycle0", scan_busy_o, 0);
    @(posedge clk_i); #1; trig_i = 1'b0;
    @(negedge clk_i);
    chk("busy_cycle1", scan_busy_o, 1);
    chk("start_cycle1", start_adc_o, 0);
    @(negedge clk_i);
    chk("start_cycle2", start_adc_o, 1);
    chk("chnr_cycle2", chnr_o, 0);
    repeat (3) @(posedge clk_i);
    #1 ch_mask_i = 8'hFF; trig_i = 1'b1;
    @(posedge clk_i); #1 trig_i = 1'b0; ch_mask_i = 8'hA1;
    wait_idle("single_idle", 200);
    chk("single_done", done_cnt - d0, 1);
    chk("single_valid", res_valid_o, 1);
    chk("single_ovr", ovr_o, 0);
    drain("single_drain");

    // Averaging over four samples on channel 4.
    plan_res = '{10, 11, 12, 14};
    plan(8'h10, 2, 1);
    chk("model_avg", exp_q[0], {5'd4, 11'd11});
    n0 = n_start;
    trig(8'h10, 2'd2);
    wait_idle("avg_idle", 200);
    chk("avg_starts", n_start - n0, 4);
    drain("avg_drain");

    // Overrun: six channels into a four-deep FIFO with no consumer.
    plan_res = '{1, 2, 3, 4, 5, 6};
    plan(8'h3F, 0, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    trig(8'h3F, 2'd0);
    wait_idle("ovr_idle", 300);
    chk("ovr_set", ovr_o, 1);
    chk("ovr_valid", res_valid_o, 1);

    // Push into full FIFO with simultaneous pop: accepted, no overrun.
    plan_res = '{9};
    plan(8'h01, 0, 1);
    trig(8'h01, 2'd0);
    @(negedge clk_i); chk("ovr_cleared", ovr_o, 0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!eoc_i && n < 50);
    chk("pushpop_eoc_seen", eoc_i, 1);
    @(posedge clk_i); #1 res_ready_i = 1'b1;
    @(posedge clk_i); #1 res_ready_i = 1'b0;
    wait_idle("pushpop_idle", 50);
    chk("pushpop_no_ovr", ovr_o, 0);
    drain("pushpop_drain");

    // Continuous rescan of channels 0 and 1.
    plan_res = '{50, 51, 52, 53, 54, 55};
    plan(8'h03, 0, 3);
    d0 = done_cnt;
    n0 = n_start;
    @(posedge clk_i); #1 res_ready_i = 1'b1; cont_i = 1'b1;
    trig(8'h03, 2'd0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (n_start - n0 < 5 && n < 300);
    chk("cont_five_starts", n_start - n0, 5);
    chk("cont_no_done", done_cnt - d0, 0);
    @(posedge clk_i); #1 cont_i = 1'b0;
    wait_idle("cont_idle", 200);
    chk("cont_done", done_cnt - d0, 1);
    drain("cont_drain");

`ifdef SARADC_DIG_CHSEQ_WDOG_EN
    // Watchdog: no eoc for 255 WAIT cycles aborts the scan.
    exp_ch.push_back(0);
    d0 = done_cnt;
    trig(8'h01, 2'd0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!start_adc_o && n < 20);
    chk("wd_start", start_adc_o, 1);
    repeat (255) @(negedge clk_i);
    chk("wd_busy_before", scan_busy_o, 1);
    chk("wd_err_before", wdog_err_o, 0);
    @(negedge clk_i);
    chk("wd_err_set", wdog_err_o, 1);
    chk("wd_idle", scan_busy_o, 0);
    chk("wd_no_done", done_cnt - d0, 0);
    plan_res = '{5};
    plan(8'h01, 0, 1);
    trig(8'h01, 2'd0);
    @(negedge clk_i); chk("wd_cleared", wdog_err_o, 0);
    wait_idle("wd_idle2", 50);
    drain("wd_drain");
`endif

    // Reset while waiting for eoc on channel 1, with a word in the FIFO.
    res_q.push_back(77);
    exp_ch.push_back(0);
    exp_ch.push_back(1);
    exp_q.push_back({5'd0, 11'd77});
    n0 = n_start;
    trig(8'h03, 2'd0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (n_start - n0 < 2 && n < 100);
    repeat (3) @(negedge clk_i);
    chk("rst_pre_valid", res_valid_o, 1);
    chk("rst_pre_chnr", chnr_o, 1);
    chk("rst_pre_busy", scan_busy_o, 1);
    d0 = done_cnt;
    @(posedge clk_i); #1 res_i = 1'b1;
    @(posedge clk_i); #1 res_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_all_zero("rst_wait");
    repeat (3) @(negedge clk_i);
    chk("rst_no_done", done_cnt - d0, 0);

    chk("exp_ch_empty", exp_ch.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
